fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer for sync_FIFO. Pops bytes whenever the FIFO is non-empty and
//  sends each one as an 8N1 UART frame on a single serial line.
//  Sits between sync_FIFO (dout/empty/re/rd_err) and the pad-level tx pin.
//  Pipeline: producer -> sync_FIFO -> fifo_uart_tx -> tx.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit, >=2
//  CNT_W         16  width of frames_sent counter
// PORTS
//  clk           in   1      system clock; all logic on posedge
//  rst           in   1      synchronous, active-high reset
//  en            in   1      1 = allowed to start new frames
//  fifo_empty    in   1      sync_FIFO empty
//  fifo_dout     in   8      sync_FIFO read data, registered in the FIFO
//  fifo_rd_err   in   1      sync_FIFO read-error strobe
//  fifo_re       out  1      read enable to sync_FIFO, registered
//  tx            out  1      serial line, idle high
//  busy          out  1      1 when state != IDLE
//  frames_sent   out  CNT_W  count of completed frames, wraps
//  err           out  1      sticky: fifo_rd_err was seen while fifo_re=1
// BEHAVIOUR
//  Reset values (next edge with rst=1): tx=1, fifo_re=0, busy=0, frames_sent=0,
//   err=0, state=IDLE, bit counter=0, baud counter=0. A frame in flight is aborted
//   and its popped byte is lost.
//  FSM: IDLE -> POP -> WAIT -> START -> DATA -> STOP -> (IDLE | POP)
//   IDLE : leave to POP when en=1 and fifo_empty=0.
//   POP  : fifo_re=1 for exactly this one cycle. Go to WAIT.
//   WAIT : the FIFO updates dout on the edge that samples re=1.
//          On the edge leaving WAIT, the shift register loads fifo_dout and the
//          state goes to START.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA : 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit index
//          counts 0..7.
//   STOP : tx=1 for CLKS_PER_BIT cycles. At the end, frames_sent is incremented.
//          Then go to POP if en=1 and fifo_empty=0, else go to IDLE.
//  tx is a registered output and is 1 in IDLE, POP, WAIT and STOP.
//   Frame length is 10*CLKS_PER_BIT cycles.
//   The back-to-back inter-frame gap is exactly 2 extra high cycles (POP and WAIT).
//  Baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state entry.
//  fifo_re is never asserted while fifo_empty=1, so rd_err can never be self-caused.
//   If fifo_rd_err=1 while fifo_re=1, err is set and the frame still completes.
//  en=0 mid-frame: the current frame completes and no new pop is issued.
//   en is sampled only in IDLE and at the end of STOP.
//  fifo_empty changing during a frame has no effect until the end of STOP.
//  frames_sent wraps from 2^CNT_W-1 to 0.
// STRUCTURE
//  Shared package fifo_uart_pkg:
//   - state encoding: localparams S_IDLE..S_STOP, 3 bits
//   - DATA_W=8
//   - FRAME_BITS=10
//  One natural sub-module: uart_baud_tick
//   - parameter CLKS_PER_BIT
//   - inputs clr and clk/rst
//   - output tick, high on the last cycle of each bit period
//  FSM, shift register and counters stay in the top level.
// TESTING
//  1 Reset: hold rst=1 for 2 edges
//    -> tx=1, fifo_re=0, busy=0, frames_sent=0, err=0.
//  2 Single byte: FIFO model holds 8'hA5, en=1
//    -> one fifo_re pulse; tx shows 0,1,0,1,0,0,1,0,1,1,
//       each bit for 16 cycles; frames_sent=1; busy falls after the stop bit.
//  3 Back-to-back: FIFO preloaded with 8'd1..8'd10
//    -> 10 frames, each with exactly 2 idle-high cycles between them;
//       frames_sent=10; no fifo_re once empty=1; err=0.
//  4 en=0 asserted mid-frame of byte 8'h3C
//    -> the frame completes intact, then IDLE with no further fifo_re
//       although empty=0; re-raise en -> the next byte is sent.
//  5 rst pulsed during the DATA bit 3 of a frame
//    -> tx=1 the next cycle, state IDLE, counters 0;
//       the following pop transmits the next FIFO byte.
//  6 Model drives fifo_rd_err=1 during the POP cycle
//    -> err=1 and stays 1 until rst; the frame still completes.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// ----------------------------------------------------------------------------
// fifo_uart_pkg
//  Shared definitions for the FIFO-fed UART transmitter.
//  - FSM state encoding (3 bits)
//  - Data and frame widths
//  - Helper to select one data bit of the byte being shifted out
// ----------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int DATA_W     = 8;   // payload bits per frame
    localparam int FRAME_BITS = 10;  // start + 8 data + stop
    localparam int STATE_W    = 3;
    localparam int BIT_IDX_W  = 3;   // indexes data bits 0..7

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_POP   = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] S_START = 3'd3;
    localparam logic [STATE_W-1:0] S_DATA  = 3'd4;
    localparam logic [STATE_W-1:0] S_STOP  = 3'd5;

    // Data bit driven on the line for a given index (LSB first on the wire).
    function automatic logic data_bit(input logic [DATA_W-1:0] data,
                                      input logic [BIT_IDX_W-1:0] idx);
        return data[idx];
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
//  Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high on the
//  last cycle of each bit period.
//  Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  restart the bit period (counter returns to 0 on the next edge)
//   tick  out high while the counter sits at CLKS_PER_BIT-1
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//  Read-side consumer for sync_FIFO: pops a byte whenever the FIFO is
//  non-empty (and en=1) and sends it as an 8N1 frame on tx.
//  Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   permission to start new frames
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data (valid the cycle after fifo_re)
//   fifo_rd_err  in   FIFO read-error strobe
//   fifo_re      out  registered one-cycle read enable (high in POP)
//   tx           out  registered serial line, idle high
//   busy         out  high whenever the FSM is not IDLE
//   frames_sent  out  completed-frame counter, wraps
//   err          out  sticky read-error flag (rd_err seen while fifo_re=1)
// ----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_rd_err,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_sent,
    output logic              err
);

    logic [STATE_W-1:0]   state_reg;
    logic [STATE_W-1:0]   state_next;
    logic [BIT_IDX_W-1:0] bit_idx_reg;
    logic [BIT_IDX_W-1:0] bit_idx_next;
    logic [DATA_W-1:0]    shift_reg;
    logic                 tx_reg;
    logic                 tx_next;
    logic                 fifo_re_reg;
    logic                 fifo_re_next;
    logic [CNT_W-1:0]     frames_reg;
    logic                 err_reg;
    logic                 tick;
    logic                 baud_clr;
    logic                 can_pop;

    // Restart the bit period on every state change so each state begins
    // with a full CLKS_PER_BIT interval.
    assign baud_clr = (state_next != state_reg);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    assign can_pop = en && !fifo_empty;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (can_pop) state_next = S_POP;
            S_POP:   state_next = S_WAIT;
            S_WAIT:  state_next = S_START;
            S_START: if (tick) state_next = S_DATA;
            S_DATA:  if (tick && (bit_idx_reg == 3'd7)) state_next = S_STOP;
            S_STOP:  if (tick) state_next = can_pop ? S_POP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. tx and fifo_re are computed from the next state
    // so the registered copies line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        bit_idx_next = bit_idx_reg;
        if (state_reg != S_DATA) begin
            bit_idx_next = '0;
        end else if (tick) begin
            bit_idx_next = bit_idx_reg + 3'd1;
        end

        fifo_re_next = (state_next == S_POP);

        tx_next = 1'b1;
        case (state_next)
            S_START: tx_next = 1'b0;
            // shift_reg is loaded on the WAIT->START edge, so it is stable
            // by the time DATA is entered.
            S_DATA:  tx_next = data_bit(shift_reg, bit_idx_next);
            default: tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit index, counters, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            fifo_re_reg <= 1'b0;
            frames_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
            fifo_re_reg <= fifo_re_next;

            // The FIFO presents the popped byte during WAIT.
            if (state_reg == S_WAIT) begin
                shift_reg <= fifo_dout;
            end

            if ((state_reg == S_STOP) && tick) begin
                frames_reg <= frames_reg + 1'b1;
            end

            // Only a read error caused by our own pop is recorded.
            if (fifo_rd_err && fifo_re_reg) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign fifo_re     = fifo_re_reg;
    assign tx          = tx_reg;
    assign busy        = (state_reg != S_IDLE);
    assign frames_sent = frames_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx
//  Directed bench for fifo_uart_tx with a small behavioural FIFO model.
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 16;
    localparam int CW  = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          fifo_rd_err;
    logic          fifo_re;
    logic          tx;
    logic          busy;
    logic [CW-1:0] frames_sent;
    logic          err;

    int total = 0;
    int bad   = 0;

    // FIFO model
    logic [7:0] mem [0:63];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  re_count = 0;
    int  re_while_empty = 0;
    logic inject_err;
    logic force_err;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_rd_err = (inject_err && fifo_re) || force_err;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_err (fifo_rd_err),
        .fifo_re     (fifo_re),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_re) begin
            re_count++;
            if (fifo_empty) begin
                re_while_empty++;
            end else begin
                fifo_dout <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Advance negedge by negedge until tx goes low; n = negedges taken.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx !== 1'b0) && (n < 2000));
        chk({tag, "_start_seen"}, {31'd0, tx}, 32'd0);
    endtask

    // Checks all 160 cycles of one frame; leaves the bench at the negedge of
    // the last stop-bit cycle. gap = idle-high cycles before the start bit.
    task automatic check_frame(input logic [7:0] b, input string tag,
                               input bit drop_en, output int gap);
        int   n;
        int   miss;
        int   bit_no;
        logic exp_bit;
        wait_start(tag, n);
        gap  = n - 1;
        miss = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c > 0) @(negedge clk);
            bit_no = c / CPB;
            if (bit_no == 0)      exp_bit = 1'b0;
            else if (bit_no == 9) exp_bit = 1'b1;
            else                  exp_bit = b[bit_no - 1];
            if (tx !== exp_bit) miss++;
            if (drop_en && (c == 50)) en = 1'b0;
        end
        chk({tag, "_bad_cycles"}, miss, 32'd0);
    endtask

    initial begin
        int   gap;
        int   n;
        logic [7:0] b;

        rst        = 1'b1;
        en         = 1'b0;
        inject_err = 1'b0;
        force_err  = 1'b0;
        fifo_dout  = 8'h00;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx",     {31'd0, tx},      32'd1);
        chk("rst_re",     {31'd0, fifo_re}, 32'd0);
        chk("rst_busy",   {31'd0, busy},    32'd0);
        chk("rst_frames", {28'd0, frames_sent}, 32'd0);
        chk("rst_err",    {31'd0, err},     32'd0);
        rst = 1'b0;
        $display("step reset checked");

        // 2: single byte
        en = 1'b1;
        push(8'hA5);
        check_frame(8'hA5, "t2_a5", 1'b0, gap);
        chk("t2_busy_in_stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t2_busy_after", {31'd0, busy}, 32'd0);
        chk("t2_frames", {28'd0, frames_sent}, 32'd1);
        chk("t2_re_count", re_count, 32'd1);
        $display("step single byte 0xa5 checked");

        // 3: back-to-back ten bytes
        en = 1'b0;
        for (int k = 1; k <= 10; k++) push(8'(k));
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            b = 8'(k);
            check_frame(b, $sformatf("t3_byte%0d", k), 1'b0, gap);
            if (k > 1) chk($sformatf("t3_gap%0d", k), gap, 32'd2);
            $display("frame byte=%0d gap=%0d", k, gap);
        end
        @(negedge clk);
        chk("t3_busy_after", {31'd0, busy}, 32'd0);
        chk("t3_frames", {28'd0, frames_sent}, 32'd11);
        repeat (20) @(negedge clk);
        chk("t3_re_count", re_count, 32'd11);
        chk("t3_re_empty", re_while_empty, 32'd0);
        chk("t3_err", {31'd0, err}, 32'd0);

        // rd_err without our pop must not set err
        force_err = 1'b1;
        @(negedge clk);
        force_err = 1'b0;
        @(negedge clk);
        chk("foreign_rd_err", {31'd0, err}, 32'd0);
        $display("step foreign rd_err checked");

        // 4: en dropped mid-frame
        push(8'h3C);
        push(8'h5A);
        check_frame(8'h3C, "t4_3c", 1'b1, gap);
        repeat (40) @(negedge clk);
        chk("t4_idle_tx", {31'd0, tx}, 32'd1);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        chk("t4_no_pop", re_count, 32'd12);
        chk("t4_frames", {28'd0, frames_sent}, 32'd12);
        en = 1'b1;
        check_frame(8'h5A, "t4_5a", 1'b0, gap);
        @(negedge clk);
        chk("t4_frames2", {28'd0, frames_sent}, 32'd13);
        $display("step en drop checked");

        // frames_sent wrap (4-bit counter: 13 -> 16 wraps to 0)
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check_frame(8'h11, "wrap_11", 1'b0, gap);
        check_frame(8'h22, "wrap_22", 1'b0, gap);
        chk("wrap_gap", gap, 32'd2);
        check_frame(8'h33, "wrap_33", 1'b0, gap);
        @(negedge clk);
        chk("wrap_frames", {28'd0, frames_sent}, 32'd0);
        $display("step counter wrap checked");

        // 5: reset during DATA bit 3
        push(8'hC3);
        push(8'h81);
        wait_start("t5_c3", n);
        repeat (16 + 3 * CPB + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_tx", {31'd0, tx}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_re", {31'd0, fifo_re}, 32'd0);
        chk("t5_frames", {28'd0, frames_sent}, 32'd0);
        rst = 1'b0;
        check_frame(8'h81, "t5_81", 1'b0, gap);
        @(negedge clk);
        chk("t5_frames_after", {28'd0, frames_sent}, 32'd1);
        $display("step mid-frame reset checked");

        // 6: read error during POP
        inject_err = 1'b1;
        push(8'h96);
        check_frame(8'h96, "t6_96", 1'b0, gap);
        inject_err = 1'b0;
        chk("t6_err_set", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("t6_frames", {28'd0, frames_sent}, 32'd2);
        repeat (20) @(negedge clk);
        chk("t6_err_sticky", {31'd0, err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_err_cleared", {31'd0, err}, 32'd0);
        chk("t6_re_empty", re_while_empty, 32'd0);
        $display("step read error checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
